// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Byte-serial program loader that writes the pipeline's instruction memory.
//   Accepts a framed image (LEN_HI, LEN_LO, 4*N big-endian instruction bytes,
//   CSUM) over a valid/ready byte stream. It writes each assembled word to
//   instruction memory and holds the pipeline in reset until the XOR checksum
//   of the frame has been verified.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   in_valid      source presents a byte on in_data
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle (combinational)
//   reload        one-cycle pulse; restarts loading from RUN or ERR
//   imem_we       instruction-memory write strobe, one cycle per word
//   imem_addr     word address of the write
//   imem_wdata    instruction word of the write
//   cpu_reset     active-high pipeline reset, released only after a good load
//   done          image loaded and checksum verified
//   error         checksum mismatch or oversize image
//   words_loaded  words written during the current load
//
// state  | meaning
// -------+----------------------------------------------------------
// LEN_HI | waiting for the high byte of the word count
// LEN_LO | waiting for the low byte; range-checks the word count
// DATA   | assembling instruction words, 4 bytes each, MSB first
// CSUM   | waiting for the checksum byte
// RUN    | image good; pipeline released, waits for reload
// ERR    | bad checksum or oversize image; waits for reload

module imem_boot_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_RUN    = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] len_q;
  logic [15:0] len_full;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic [7:0]  acc_q;

  logic        accept;
  logic        word_done;
  logic        last_word;
  logic        reload_ok;

  assign accept    = in_valid & in_ready;
  // The low length byte is still on in_data when LEN_LO decides the next state.
  assign len_full  = {len_q[15:8], in_data};
  assign word_done = accept && (state == S_DATA) && (byte_cnt == 2'd3);
  // words_loaded still counts completed words while the 4th byte is on the bus.
  assign last_word = ((32'(words_loaded) + 32'd1) == 32'(len_q));
  assign reload_ok = reload && ((state == S_RUN) || (state == S_ERR));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_LEN_HI;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN_HI: begin
        if (accept) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if (32'(len_full) > (32'd1 << ADDR_W)) begin
            state_nxt = S_ERR;
          end else if (len_full == 16'd0) begin
            state_nxt = S_CSUM;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_done && last_word) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_nxt = (in_data == acc_q) ? S_RUN : S_ERR;
      end
      S_RUN, S_ERR: begin
        if (reload) state_nxt = S_LEN_HI;
      end
      default: state_nxt = S_LEN_HI;
    endcase
  end

  // Output logic. in_ready is gated by reset so that no byte looks accepted
  // while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: in_ready = reset;
      default:                            in_ready = 1'b0;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q        <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      acc_q        <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= '0;
      words_loaded <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      imem_we <= word_done;

      if (accept && (state != S_CSUM)) begin
        acc_q <= acc_q ^ in_data;
      end

      if (accept && (state == S_LEN_HI)) begin
        len_q[15:8] <= in_data;
        byte_cnt    <= '0;
      end

      if (accept && (state == S_LEN_LO)) begin
        len_q[7:0] <= in_data;
      end

      if (accept && (state == S_DATA)) begin
        asm_q    <= {asm_q[15:0], in_data};
        byte_cnt <= byte_cnt + 2'd1;
      end

      // Address wraps modulo the memory depth; oversize is caught at LEN_LO.
      if (word_done) begin
        imem_wdata   <= {asm_q, in_data};
        imem_addr    <= BASE_ADDR + words_loaded[ADDR_W-1:0];
        words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
      end

      if (reload_ok) begin
        len_q        <= '0;
        byte_cnt     <= '0;
        acc_q        <= '0;
        words_loaded <= '0;
      end

      cpu_reset <= (state_nxt != S_RUN);
      done      <= (state_nxt == S_RUN);
      error     <= (state_nxt == S_ERR);
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-serial program loader; the writer side of the pipeline's instruction memory.
- Receives a framed program image over a valid/ready byte stream and assembles big-endian 32-bit words.
- Writes each word into instruction memory and holds the pipeline in reset until the image is loaded and its checksum verified.
- Sits between the bench/host byte source and the Pipeline's instruction-memory write port and reset input.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2^ADDR_W words.
- BASE_ADDR, 0, word address of the first loaded instruction (ADDR_W bits).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  one-cycle pulse; restarts loading from RUN or ERR.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  instruction word for the write.
- cpu_reset  output  1  active-high reset to the Pipeline; 1 until the load succeeds.
- done  output  1  image loaded and checksum OK.
- error  output  1  checksum mismatch or oversize image.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N instruction bytes (MSB first per word), then CSUM.
- CSUM = XOR of every preceding byte of the frame, including the length bytes.
- A byte is accepted only on a rising edge with in_valid=1 and in_ready=1.
- in_ready is combinational: 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in RUN and ERR; forced 0 while reset is asserted.
- Reset (async, reset=0):
  - state=LEN_HI, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_reset=1, done=0, error=0, words_loaded=0.
  - Byte counter, word count and XOR accumulator cleared.
- States and transitions:
  - LEN_HI -> LEN_LO on accept.
  - LEN_LO -> on accept:
    - N > 2^ADDR_W: -> ERR.
    - N == 0: -> CSUM.
    - otherwise: -> DATA.
  - DATA: shift each byte into a 32-bit assembly register. On the 4th byte of a word:
    - Next cycle: imem_we=1 for exactly one cycle, with imem_wdata = assembled word and imem_addr = BASE_ADDR + words_loaded (mod 2^ADDR_W).
    - words_loaded increments in that same cycle.
    - After the N-th word: -> CSUM.
  - CSUM -> on accept:
    - Byte == XOR accumulator: -> RUN.
    - Otherwise: -> ERR.
  - RUN: cpu_reset=0, done=1 (both registered, effective the cycle after the CSUM byte is accepted).
  - ERR: error=1, cpu_reset held at 1, done=0.
- reload:
  - Honoured only in RUN or ERR. Next cycle: state=LEN_HI, cpu_reset=1, done=0, error=0, words_loaded=0, accumulator cleared.
  - Ignored in all other states.
- Throughput: one byte per cycle when in_valid is held high. in_valid gaps stall without losing state.
- Simultaneous events:
  - The imem_we pulse of the last word and acceptance of the CSUM byte may occur in the same cycle; both take effect.
  - Reset overrides reload.
- Reset mid-operation: the partial image is abandoned, no further imem_we is issued, and all outputs return to their reset values.
- Addressing: BASE_ADDR + N exceeding the memory depth wraps modulo 2^ADDR_W; no error is raised.
- words_loaded is ADDR_W+1 bits so that N = 2^ADDR_W is representable.

Test Plan:
1. Stream 00 02 20 08 00 05 20 09 00 0A 0C -> imem_we at addr 0 data 20080005, then addr 1 data 2009000A; cpu_reset falls the cycle after byte 0C; done=1; words_loaded=2; in_ready=0.
2. Same stream with CSUM 0D -> both words written, error=1, done=0, cpu_reset stays 1; in_ready=0 thereafter.
3. N=0 stream 00 00 00 -> no imem_we; RUN with done=1, cpu_reset=0.
4. ADDR_W=8, stream 01 01 -> ERR immediately after LEN_LO, error=1, no imem_we, remaining bytes not accepted.
5. Scenario 1 with random 0-3 cycle in_valid gaps -> identical writes and final state; one imem_we pulse per word.
6. reset=0 after 6 bytes of scenario 1 -> outputs at reset values, words_loaded=0. Then replay scenario 1, pulse reload in RUN, and replay again -> each run completes with done=1, and cpu_reset=1 between runs.
